// File: rtl/mips_pkg.sv
// Shared types and widths for the pipeline hazard logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // Register-index width of the integer register file.
  localparam int REG_IDX_W = 5;

  // Width of the optional hazard statistics counters.
  localparam int STAT_W = 16;

  // Hazard unit control state: normal issue, or holding for a mult/div.
  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; counts qualifying cycles and sticks at all-ones.
// Latency: count visible the cycle after i_inc is sampled.
// Backpressure: none; i_inc is sampled every cycle, rst clears synchronously.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high clear
//   i_inc - increment request for this cycle
//   o_cnt - current count (saturates at all-ones)
module sat_counter
  import mips_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stall, mult/div hold and taken-branch flush.
// Latency: all outputs combinational from registered state + current inputs.
// Backpressure: drives stage enables low to hold PC/IF/ID; flushes insert bubbles.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   memRead_IDEX, RD_IDEX         - EX-stage load flag and destination register
//   RS1_IFID, RS2_IFID, usesRS2_IFID - ID-stage sources and RS2-use flag
//   branchTaken_EX                - branch/jump resolved taken in EX
//   mdStart_IDEX                  - EX-stage instruction is a mult/div
//   PCWrite, IFIDWrite, IDEXWrite - stage enables (0 holds the stage)
//   IDEXFlush, IFIDFlush, EXMEMFlush - bubble insertion
//   mdBusy                        - unit is holding for a mult/div
//   luStallCnt, mdStallCnt, flushCnt - statistics (only with HAZARD_STATS_EN)
//
// Build option: define HAZARD_STATS_EN to add the saturating statistics counters.
// MD_LATENCY is the total mult/div stall in cycles; legal range 2..15.
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memRead_IDEX,
  input  logic [REG_IDX_W-1:0] RD_IDEX,
  input  logic [REG_IDX_W-1:0] RS1_IFID,
  input  logic [REG_IDX_W-1:0] RS2_IFID,
  input  logic                 usesRS2_IFID,
  input  logic                 branchTaken_EX,
  input  logic                 mdStart_IDEX,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IDEXWrite,
  output logic                 IDEXFlush,
  output logic                 IFIDFlush,
  output logic                 EXMEMFlush,
  output logic                 mdBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]    luStallCnt,
  output logic [STAT_W-1:0]    mdStallCnt,
  output logic [STAT_W-1:0]    flushCnt
`endif
);

  localparam int CNT_W = $clog2(MD_LATENCY + 1);
  // The start cycle is the first stall cycle, so the busy phase covers the rest.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  hcu_state_t       r_state;
  hcu_state_t       w_next_state;
  logic [CNT_W-1:0] r_md_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_load_use;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_load_use = memRead_IDEX && (RD_IDEX != '0) &&
                      ((RD_IDEX == RS1_IFID) ||
                       (usesRS2_IFID && (RD_IDEX == RS2_IFID)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_md_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_md_cnt;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    IDEXFlush    = 1'b0;
    IFIDFlush    = 1'b0;
    EXMEMFlush   = 1'b0;
    mdBusy       = 1'b0;

    // Reset forces default outputs even if the state register still says busy.
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (branchTaken_EX) begin
            // Branch wins over load-use and mdStart: squash the wrong-path
            // IF and ID instructions and let PC load the target.
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
          end else if (mdStart_IDEX) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            IDEXWrite    = 1'b0;
            EXMEMFlush   = 1'b1;
            w_next_state = MD_BUSY;
            w_next_cnt   = CNT_LOAD;
          end else if (w_load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end
        end
        MD_BUSY: begin
          // Held mult/div keeps asserting mdStart; branch and load-use
          // are ignored until the hold ends.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXWrite  = 1'b0;
          EXMEMFlush = 1'b1;
          mdBusy     = 1'b1;
          if (r_md_cnt <= CNT_W'(1)) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_next_cnt = r_md_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_next_state = RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic w_lu_stall;
  logic w_md_stall;
  logic w_br_flush;

  // Classify the cycle from the outputs: only a mult/div hold drops IDEXWrite,
  // only a branch raises IFIDFlush, and load-use is the remaining ID/EX bubble.
  assign w_md_stall = !IDEXWrite;
  assign w_br_flush = IFIDFlush;
  assign w_lu_stall = IDEXFlush && !IFIDFlush;

  sat_counter #(.W(STAT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_lu_stall),
    .o_cnt (luStallCnt)
  );

  sat_counter #(.W(STAT_W)) u_md_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_md_stall),
    .o_cnt (mdStallCnt)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_br_flush),
    .o_cnt (flushCnt)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit (MD_LATENCY = 4).
// Latency: outputs checked on the falling edge of the cycle the inputs apply.
// Backpressure: n/a; stimulus table drives one step per cycle.
module tb_hazard_control_unit;
  import mips_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 memRead_IDEX;
  logic [REG_IDX_W-1:0] RD_IDEX;
  logic [REG_IDX_W-1:0] RS1_IFID;
  logic [REG_IDX_W-1:0] RS2_IFID;
  logic                 usesRS2_IFID;
  logic                 branchTaken_EX;
  logic                 mdStart_IDEX;
  logic                 PCWrite, IFIDWrite, IDEXWrite;
  logic                 IDEXFlush, IFIDFlush, EXMEMFlush;
  logic                 mdBusy;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0]    luStallCnt, mdStallCnt, flushCnt;
`endif

  hazard_control_unit #(.MD_LATENCY(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .memRead_IDEX   (memRead_IDEX),
    .RD_IDEX        (RD_IDEX),
    .RS1_IFID       (RS1_IFID),
    .RS2_IFID       (RS2_IFID),
    .usesRS2_IFID   (usesRS2_IFID),
    .branchTaken_EX (branchTaken_EX),
    .mdStart_IDEX   (mdStart_IDEX),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IDEXWrite      (IDEXWrite),
    .IDEXFlush      (IDEXFlush),
    .IFIDFlush      (IFIDFlush),
    .EXMEMFlush     (EXMEMFlush),
    .mdBusy         (mdBusy)
`ifdef HAZARD_STATS_EN
    ,
    .luStallCnt     (luStallCnt),
    .mdStallCnt     (mdStallCnt),
    .flushCnt       (flushCnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: {PCWrite, IFIDWrite, IDEXWrite,
  //                       IDEXFlush, IFIDFlush, EXMEMFlush, mdBusy}
  localparam logic [6:0] E_DEF  = 7'b111_000_0;
  localparam logic [6:0] E_LU   = 7'b001_100_0;
  localparam logic [6:0] E_MDST = 7'b000_001_0;
  localparam logic [6:0] E_MDBZ = 7'b000_001_1;
  localparam logic [6:0] E_BR   = 7'b111_110_0;

  typedef struct {
    logic       rs;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       u2;
    logic       br;
    logic       md;
    logic [6:0] e;
  } step_t;

  step_t      steps[$];
  logic [6:0] exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic rs, input logic mr, input logic [4:0] rd,
                     input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                     input logic br, input logic md, input logic [6:0] e);
    step_t s;
    s = '{rs: rs, mr: mr, rd: rd, r1: r1, r2: r2, u2: u2, br: br, md: md, e: e};
    steps.push_back(s);
  endtask

  task automatic run_steps(input int lo, input int hi);
    logic [6:0] got;
    logic [6:0] want;
    for (int i = lo; i <= hi; i++) begin
      @(posedge clk);
      #1;
      rst            = steps[i].rs;
      memRead_IDEX   = steps[i].mr;
      RD_IDEX        = steps[i].rd;
      RS1_IFID       = steps[i].r1;
      RS2_IFID       = steps[i].r2;
      usesRS2_IFID   = steps[i].u2;
      branchTaken_EX = steps[i].br;
      mdStart_IDEX   = steps[i].md;
      exp_q.push_back(steps[i].e);
      @(negedge clk);
      got  = {PCWrite, IFIDWrite, IDEXWrite, IDEXFlush, IFIDFlush, EXMEMFlush, mdBusy};
      want = exp_q.pop_front();
      chk($sformatf("step%0d", i), {9'd0, got}, {9'd0, want});
    end
  endtask

  // branchTaken_EX with mdStart_IDEX while issuing is an illegal pairing.
  always @(negedge clk) begin
    if (rst === 1'b0 && mdBusy === 1'b0) begin
      assert (!(branchTaken_EX && mdStart_IDEX))
        else $error("illegal branchTaken_EX with mdStart_IDEX in RUN");
    end
  end

  initial begin
    rst            = 1'b1;
    memRead_IDEX   = 1'b0;
    RD_IDEX        = '0;
    RS1_IFID       = '0;
    RS2_IFID       = '0;
    usesRS2_IFID   = 1'b0;
    branchTaken_EX = 1'b0;
    mdStart_IDEX   = 1'b0;

    //   rs mr rd     r1     r2     u2 br md exp
    add(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 0  reset
    add(1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, E_DEF);   // 1  reset masks hazards
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 2  idle
    add(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, E_LU);    // 3  lw x5 -> use x5
    add(0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, E_DEF);   // 4  bubble passed
    add(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, E_DEF);   // 5  x0 never hazards
    add(0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, E_DEF);   // 6  RS2 unused
    add(0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, E_LU);    // 7  RS2 used
    add(0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, E_BR);    // 8  branch beats load-use
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, E_BR);    // 9  plain branch
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, E_MDST);  // 10 mdStart, t
    add(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 1, E_MDBZ);  // 11 t+1, load-use ignored
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, E_MDBZ);  // 12 t+2, branch ignored
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, E_MDBZ);  // 13 t+3
    add(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, E_LU);    // 14 t+4 RUN, load-use live
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 15 idle
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, E_MDST);  // 16 mdStart, t
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, E_MDBZ);  // 17 t+1
    add(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, E_DEF);   // 18 t+2 reset aborts
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 19 t+3 RUN
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 20 no resumed stall
    add(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, E_DEF);   // 21

    run_steps(0, 15);
`ifdef HAZARD_STATS_EN
    chk("lu_cnt", luStallCnt, 16'd3);
    chk("md_cnt", mdStallCnt, 16'd4);
    chk("fl_cnt", flushCnt, 16'd2);
`endif
    run_steps(16, 21);

`ifdef HAZARD_STATS_EN
    @(posedge clk);
    #1;
    mdStart_IDEX = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("md_sat", mdStallCnt, 16'hFFFF);
    @(posedge clk);
    #1;
    mdStart_IDEX = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("md_clr", mdStallCnt, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
